// File: rtl/exec_system_seq_pkg.sv
// Shared exec-stage types: privilege levels, trap causes,
// mstatus bit positions and SYSTEM decode constants.
package exec_system_seq_pkg;

    typedef enum logic [1:0] {
        PRIV_U = 2'b00,
        PRIV_S = 2'b01,
        PRIV_M = 2'b11
    } priv_levels_e;

    typedef enum logic [3:0] {
        CAUSE_ILLEGAL    = 4'd2,
        CAUSE_BREAKPOINT = 4'd3,
        CAUSE_ECALL_U    = 4'd8,
        CAUSE_ECALL_S    = 4'd9,
        CAUSE_ECALL_M    = 4'd11
    } trap_causes_e;

    localparam int MS_SIE    = 1;
    localparam int MS_MIE    = 3;
    localparam int MS_SPIE   = 5;
    localparam int MS_MPIE   = 7;
    localparam int MS_SPP    = 8;
    localparam int MS_MPP_LO = 11;
    localparam int MS_MPP_HI = 12;
    localparam int MS_MPRV   = 17;
    localparam int MS_TVM    = 20;
    localparam int MS_TW     = 21;
    localparam int MS_TSR    = 22;

    localparam logic [6:0] F7_PRIV   = 7'b0000000;
    localparam logic [6:0] F7_MRET   = 7'b0011000;
    localparam logic [6:0] F7_SYS    = 7'b0001000;
    localparam logic [6:0] F7_SFENCE = 7'b0001001;

    localparam logic [4:0] RS2_ECALL  = 5'd0;
    localparam logic [4:0] RS2_EBREAK = 5'd1;
    localparam logic [4:0] RS2_XRET   = 5'd2;
    localparam logic [4:0] RS2_WFI    = 5'd5;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WFI_WAIT,
        ST_RESP
    } sys_state_e;

endpackage

// File: rtl/exec_system_seq_wfi_ctr.sv
// WFI timeout counter: counts enabled cycles up to
// LIMIT and holds there, flagging expiry.
module exec_system_wfi_ctr
    import exec_system_seq_pkg::*;
#(
    parameter int LIMIT = 16,
    localparam int W = $clog2(LIMIT + 1)
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam logic [W-1:0] LIM = W'(LIMIT);

    logic [W-1:0] cnt;

    // Saturating up-counter, cleared outside WFI_WAIT
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en && (cnt != LIM)) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign expired = (cnt == LIM);

endmodule

// File: rtl/exec_system_seq.sv
// SYSTEM (funct3==0) executor: ECALL/EBREAK/xRET/
// SFENCE.VMA/WFI with valid/ready and registered result.
module exec_system_seq
    import exec_system_seq_pkg::*;
#(
    parameter int XLEN         = 64,
    parameter int HAS_SMODE    = 1,
    parameter int WFI_STALL    = 1,
    parameter int WFI_TW_LIMIT = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [4:0]      rd,
    input  logic [4:0]      rs1,
    input  logic [4:0]      rs2,
    input  logic [2:0]      funct3,
    input  logic [6:0]      funct7,
    input  logic [1:0]      privilege_mode,
    input  logic [XLEN-1:0] mstatus,
    input  logic [XLEN-1:0] mepc,
    input  logic [XLEN-1:0] sepc,
    input  logic            irq_pending,
    output logic            out_valid,
    input  logic            out_ready,
    output logic            out_exception,
    output logic [3:0]      out_trap_cause,
    output logic            out_is_xret,
    output logic [XLEN-1:0] out_result,
    output logic            out_update_mstatus,
    output logic [XLEN-1:0] out_new_mstatus,
    output logic [1:0]      out_new_priv,
    output logic            out_sfence
);

    sys_state_e state, state_nxt;

    logic accept, wfi_tw, ctr_clr, ctr_en, ctr_expired;
    logic base_ok, is_sfence, d_ill, d_wfi;
    logic d_exc, d_xret, d_upd, d_sfence;
    logic [3:0] d_cause;
    logic [1:0] d_priv, mpp;
    logic [XLEN-1:0] d_result, d_ms;

    assign in_ready  = (state == ST_IDLE);
    assign accept    = in_valid & in_ready & ~flush;
    assign ctr_clr   = flush | (state != ST_WFI_WAIT);
    assign ctr_en    = (state == ST_WFI_WAIT) & wfi_tw;
    assign is_sfence = (funct7 == F7_SFENCE);
    assign mpp       = mstatus[MS_MPP_HI:MS_MPP_LO];
    assign base_ok   = (funct3 == 3'd0) && (rd == 5'd0)
                    && (is_sfence || (rs1 == 5'd0));

    exec_system_wfi_ctr #(
        .LIMIT(WFI_TW_LIMIT)
    ) u_wfi_ctr (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (ctr_clr),
        .en     (ctr_en),
        .expired(ctr_expired)
    );

    // Decode the offered instruction into its retire result
    always_comb begin
        d_ill    = 1'b0;
        d_wfi    = 1'b0;
        d_exc    = 1'b0;
        d_cause  = 4'd0;
        d_xret   = 1'b0;
        d_result = '0;
        d_upd    = 1'b0;
        d_ms     = '0;
        d_priv   = 2'b00;
        d_sfence = 1'b0;
        if (!base_ok) begin
            d_ill = 1'b1;
        end else begin
            unique case (1'b1)
                (funct7 == F7_PRIV) && (rs2 == RS2_ECALL): begin
                    d_exc = 1'b1;
                    unique case (privilege_mode)
                        PRIV_U:  d_cause = CAUSE_ECALL_U;
                        PRIV_S:  d_cause = CAUSE_ECALL_S;
                        default: d_cause = CAUSE_ECALL_M;
                    endcase
                end
                (funct7 == F7_PRIV) && (rs2 == RS2_EBREAK): begin
                    d_exc   = 1'b1;
                    d_cause = CAUSE_BREAKPOINT;
                end
                (funct7 == F7_MRET) && (rs2 == RS2_XRET): begin
                    if (privilege_mode != PRIV_M) begin
                        d_ill = 1'b1;
                    end else begin
                        d_xret   = 1'b1;
                        d_upd    = 1'b1;
                        d_result = mepc;
                        d_priv   = mpp;
                        d_ms     = mstatus;
                        d_ms[MS_MIE]  = mstatus[MS_MPIE];
                        d_ms[MS_MPIE] = 1'b1;
                        d_ms[MS_MPP_HI:MS_MPP_LO] = PRIV_U;
                        if (mpp != PRIV_M) d_ms[MS_MPRV] = 1'b0;
                    end
                end
                (funct7 == F7_SYS) && (rs2 == RS2_XRET): begin
                    if ((HAS_SMODE == 0) || (privilege_mode == PRIV_U)
                        || ((privilege_mode == PRIV_S) && mstatus[MS_TSR])) begin
                        d_ill = 1'b1;
                    end else begin
                        d_xret   = 1'b1;
                        d_upd    = 1'b1;
                        d_result = sepc;
                        d_priv   = mstatus[MS_SPP] ? PRIV_S : PRIV_U;
                        d_ms     = mstatus;
                        d_ms[MS_SPP]  = 1'b0;
                        d_ms[MS_SIE]  = mstatus[MS_SPIE];
                        d_ms[MS_SPIE] = 1'b1;
                        d_ms[MS_MPRV] = 1'b0;
                    end
                end
                is_sfence: begin
                    if ((HAS_SMODE == 0) || (privilege_mode == PRIV_U)
                        || ((privilege_mode == PRIV_S) && mstatus[MS_TVM])) begin
                        d_ill = 1'b1;
                    end else begin
                        d_sfence = 1'b1;
                    end
                end
                (funct7 == F7_SYS) && (rs2 == RS2_WFI): begin
                    d_wfi = !irq_pending && (WFI_STALL != 0);
                end
                default: d_ill = 1'b1;
            endcase
        end
        if (d_ill) begin
            d_exc    = 1'b1;
            d_cause  = CAUSE_ILLEGAL;
            d_xret   = 1'b0;
            d_result = '0;
            d_upd    = 1'b0;
            d_ms     = '0;
            d_priv   = 2'b00;
            d_sfence = 1'b0;
            d_wfi    = 1'b0;
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    // Next state; a flush always lands in IDLE
    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE:     if (accept) state_nxt = d_wfi ? ST_WFI_WAIT : ST_RESP;
            ST_WFI_WAIT: if (irq_pending || ctr_expired) state_nxt = ST_RESP;
            ST_RESP:     if (out_ready) state_nxt = ST_IDLE;
            default:     state_nxt = ST_IDLE;
        endcase
        if (flush) state_nxt = ST_IDLE;
    end

    // Result registers; held until handshake, zeroed on leave
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wfi_tw             <= 1'b0;
            out_valid          <= 1'b0;
            out_exception      <= 1'b0;
            out_trap_cause     <= 4'd0;
            out_is_xret        <= 1'b0;
            out_result         <= '0;
            out_update_mstatus <= 1'b0;
            out_new_mstatus    <= '0;
            out_new_priv       <= 2'b00;
            out_sfence         <= 1'b0;
        end else if (flush || ((state == ST_RESP) && out_ready)) begin
            wfi_tw             <= 1'b0;
            out_valid          <= 1'b0;
            out_exception      <= 1'b0;
            out_trap_cause     <= 4'd0;
            out_is_xret        <= 1'b0;
            out_result         <= '0;
            out_update_mstatus <= 1'b0;
            out_new_mstatus    <= '0;
            out_new_priv       <= 2'b00;
            out_sfence         <= 1'b0;
        end else if (accept) begin
            wfi_tw <= (privilege_mode != PRIV_M) && mstatus[MS_TW];
            if (!d_wfi) begin
                out_valid          <= 1'b1;
                out_exception      <= d_exc;
                out_trap_cause     <= d_cause;
                out_is_xret        <= d_xret;
                out_result         <= d_result;
                out_update_mstatus <= d_upd;
                out_new_mstatus    <= d_ms;
                out_new_priv       <= d_priv;
                out_sfence         <= d_sfence;
            end
        end else if (state == ST_WFI_WAIT) begin
            if (irq_pending) begin
                out_valid <= 1'b1;
            end else if (ctr_expired) begin
                out_valid      <= 1'b1;
                out_exception  <= 1'b1;
                out_trap_cause <= CAUSE_ILLEGAL;
            end
        end
    end

endmodule
